// File: rtl/typing_pkg.sv
// typing_pkg: shared constants, spawner state encoding and the LFSR step function
// Contents: NUM_COLS_DEFAULT, ASCII_LOWER_A, ASCII_ZERO, CHARSET_LETTERS, CHARSET_ALNUM,
//   LFSR_MASK, spawn_state_t, lfsr_next() (one Galois step, right-shifting)
package typing_pkg;
  localparam int NUM_COLS_DEFAULT = 53;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam int CHARSET_LETTERS = 26;
  localparam int CHARSET_ALNUM = 36;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ROLL,
    S_PROBE0,
    S_PROBE1,
    S_WRITE,
    S_COOL
  } spawn_state_t;
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Galois LFSR that advances one step per cycle with step high
// Ports: clk, reset (async, active-high, loads seed), step (advance enable),
//   seed [15:0] (reset value, must be nonzero), value [15:0] (current state)
module lfsr16
  import typing_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] value
);
  logic [15:0] value_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) value_q <= seed;
    else if (step) value_q <= lfsr_next(value_q);
  assign value = value_q;
endmodule

// File: rtl/char_spawner.sv
// char_spawner: picks a random free column/char/speed and requests a video-memory write
// Ports: clk, reset (async, active-high), pause (low = no new round), mode (unused here),
//   wr_ready (target slot empty), vmdata_wr/vmdata_wraddr/veldata_wr (write payload),
//   vmdata_wren (held request), spawn_count/drop_count (saturating), busy (not IDLE)
// Build option: SPAWN_DIGITS_EN adds '0'-'9' to the character set.
module char_spawner
  import typing_pkg::*;
#(
  parameter int          NUM_COLS     = NUM_COLS_DEFAULT,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          MAX_RETRY    = 8,
  parameter int          WAIT_TIMEOUT = 28_000_000,
  parameter int          COOLDOWN_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pause,
  input  logic [1:0]  mode,
  input  logic        wr_ready,
  output logic [7:0]  vmdata_wr,
  output logic [5:0]  vmdata_wraddr,
  output logic        vmdata_wren,
  output logic [7:0]  veldata_wr,
  output logic [13:0] spawn_count,
  output logic [7:0]  drop_count,
  output logic        busy
);
`ifdef SPAWN_DIGITS_EN
  localparam int CHARSET = CHARSET_ALNUM;
`else
  localparam int CHARSET = CHARSET_LETTERS;
`endif
  spawn_state_t state_q, state_d;
  logic [15:0] lfsr_val, lfsr_nxt;
  logic [5:0] col_q, col_d, roll_col;
  logic [7:0] char_q, char_d, vel_q, vel_d, roll_char, roll_vel, idx;
  logic wren_q, wren_d, give_up;
  logic [13:0] spawn_q, spawn_d;
  logic [7:0] drop_q, drop_d, retry_q, retry_d;
  logic [31:0] timer_q, timer_d;
  logic unused_mode;
  // mode only changes the engine's commit rate; the spawner ignores it
  assign unused_mode = ^mode;
  lfsr16 u_lfsr (
    .clk  (clk),
    .reset(reset),
    .step (state_q == S_ROLL),
    .seed (LFSR_SEED),
    .value(lfsr_val)
  );
  // outputs registered in ROLL come from the value the LFSR steps to in that same cycle
  assign lfsr_nxt = lfsr_next(lfsr_val);
  assign roll_col = 6'(8'd1 + lfsr_nxt[15:8] % 8'(NUM_COLS - 1));
  assign idx = lfsr_nxt[7:0] % 8'(CHARSET);
  assign roll_char = idx < 8'(CHARSET_LETTERS) ? ASCII_LOWER_A + idx
                                                 : ASCII_ZERO + idx - 8'(CHARSET_LETTERS);
  assign roll_vel = {lfsr_nxt[3:0], lfsr_nxt[15:12]};
  assign give_up = retry_q + 8'd1 == 8'(MAX_RETRY);
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    char_d = char_q;
    vel_d = vel_q;
    wren_d = wren_q;
    spawn_d = spawn_q;
    drop_d = drop_q;
    retry_d = retry_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: state_d = pause ? S_ROLL : S_IDLE;
      S_ROLL: begin
        col_d = roll_col;
        char_d = roll_char;
        vel_d = roll_vel;
        state_d = S_PROBE0;
      end
      S_PROBE0: state_d = S_PROBE1;
      S_PROBE1: begin
        retry_d = wr_ready || give_up ? '0 : retry_q + 8'd1;
        state_d = wr_ready ? S_WRITE : give_up ? S_COOL : S_ROLL;
        wren_d = wr_ready;
        timer_d = '0;
      end
      S_WRITE: begin
        timer_d = timer_q + 32'd1;
        // a commit seen on the timeout cycle still counts as a commit
        if (!wr_ready) begin
          spawn_d = spawn_q + {13'd0, ~&spawn_q};
          wren_d = 1'b0;
          timer_d = '0;
          state_d = S_COOL;
        end else if (timer_q == 32'(WAIT_TIMEOUT - 1)) begin
          drop_d = drop_q + {7'd0, ~&drop_q};
          wren_d = 1'b0;
          timer_d = '0;
          state_d = S_COOL;
        end
      end
      S_COOL: begin
        timer_d = timer_q == 32'(COOLDOWN_CYC - 1) ? '0 : timer_q + 32'd1;
        state_d = timer_q == 32'(COOLDOWN_CYC - 1) ? S_IDLE : S_COOL;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      col_q <= '0;
      char_q <= '0;
      vel_q <= '0;
      wren_q <= 1'b0;
      spawn_q <= '0;
      drop_q <= '0;
      retry_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      char_q <= char_d;
      vel_q <= vel_d;
      wren_q <= wren_d;
      spawn_q <= spawn_d;
      drop_q <= drop_d;
      retry_q <= retry_d;
      timer_q <= timer_d;
    end
  assign vmdata_wr = char_q;
  assign vmdata_wraddr = col_q;
  assign vmdata_wren = wren_q;
  assign veldata_wr = vel_q;
  assign spawn_count = spawn_q;
  assign drop_count = drop_q;
  assign busy = state_q != S_IDLE;
endmodule

// File: tb/tb_char_spawner.sv
// tb_char_spawner: scoreboard bench for char_spawner with a randomized engine model
module tb_char_spawner;
  localparam int WTO = 64;
  localparam int COOL = 16;
  localparam int NROUNDS = 120;
  typedef struct {
    logic [5:0] col;
    logic [7:0] ch;
    logic [7:0] vel;
    int dur;
  } item_t;
  logic clk, reset, pause, wr_ready;
  logic [1:0] mode;
  logic [7:0] vmdata_wr, veldata_wr, drop_count;
  logic [5:0] vmdata_wraddr;
  logic vmdata_wren, busy;
  logic [13:0] spawn_count;
  int total = 0, bad = 0;
  item_t exp_q[$];
  int plan_q[$];
  bit occ[64];
  logic [15:0] m_lfsr;
  int exp_spawn = 0, exp_drop = 0;

  char_spawner #(
    .NUM_COLS(53), .LFSR_SEED(16'hACE1), .MAX_RETRY(8), .WAIT_TIMEOUT(WTO), .COOLDOWN_CYC(COOL)
  ) dut (
    .clk(clk), .reset(reset), .pause(pause), .mode(mode), .wr_ready(wr_ready),
    .vmdata_wr(vmdata_wr), .vmdata_wraddr(vmdata_wraddr), .vmdata_wren(vmdata_wren),
    .veldata_wr(veldata_wr), .spawn_count(spawn_count), .drop_count(drop_count), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] m_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction
  function automatic int m_col(input logic [15:0] l);
    return 1 + int'(l[15:8]) % 52;
  endfunction
  function automatic logic [7:0] m_char(input logic [15:0] l);
    int i;
`ifdef SPAWN_DIGITS_EN
    i = int'(l[7:0]) % 36;
`else
    i = int'(l[7:0]) % 26;
`endif
    return i < 26 ? 8'(97 + i) : 8'(48 + i - 26);
  endfunction

  // One spawn round: up to 8 rolls, the first free column becomes the expected write.
  task automatic plan_round(input int cat, output bit wrote);
    int r = 0;
    wrote = 0;
    while (r < 8) begin
      m_lfsr = m_step(m_lfsr);
      if (!occ[m_col(m_lfsr)]) begin
        exp_q.push_back('{col: 6'(m_col(m_lfsr)), ch: m_char(m_lfsr),
                          vel: {m_lfsr[3:0], m_lfsr[15:12]}, dur: cat < WTO ? cat + 1 : WTO});
        plan_q.push_back(cat);
        if (cat < WTO) exp_spawn++;
        else exp_drop++;
        wrote = 1;
        return;
      end
      r++;
    end
  endtask

  task automatic wait_for(input bit is_wren, input logic val, input string nm);
    int n = 0;
    while ((is_wren ? vmdata_wren : busy) !== val && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n == 5000) chk(nm, is_wren ? vmdata_wren : busy, val);
  endtask

  // engine: slot emptiness from the occupancy map; commits after the planned hold
  bit e_prev;
  int e_hold, e_cat;
  initial begin
    wr_ready = 0;
    e_prev = 0;
    e_hold = 0;
    e_cat = 0;
    forever begin
      @(negedge clk);
      if (vmdata_wren && !e_prev) begin
        e_cat = plan_q.size() > 0 ? plan_q.pop_front() : 100000;
        e_hold = 0;
      end
      if (vmdata_wren) begin
        wr_ready = e_hold != e_cat;
        e_hold++;
      end else wr_ready = !occ[vmdata_wraddr];
      e_prev = vmdata_wren;
    end
  end

  // monitor: pops the scoreboard on each write request and checks payload, hold and length
  bit m_inw;
  int m_dur, m_unst;
  item_t cur;
  initial begin
    m_inw = 0;
    m_dur = 0;
    m_unst = 0;
    forever begin
      @(negedge clk);
      if (reset) m_inw = 0;
      else if (vmdata_wren && !m_inw) begin
        m_inw = 1;
        m_dur = 1;
        m_unst = 0;
        chk("write_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          chk("col", vmdata_wraddr, cur.col);
          chk("char", vmdata_wr, cur.ch);
          chk("vel", veldata_wr, cur.vel);
        end else cur = '{col: vmdata_wraddr, ch: vmdata_wr, vel: veldata_wr, dur: -1};
        chk("col_range", int'(vmdata_wraddr >= 1 && vmdata_wraddr <= 52), 1);
`ifdef SPAWN_DIGITS_EN
        chk("char_range", int'((vmdata_wr >= 8'h61 && vmdata_wr <= 8'h7a) ||
                              (vmdata_wr >= 8'h30 && vmdata_wr <= 8'h39)), 1);
`else
        chk("char_range", int'(vmdata_wr >= 8'h61 && vmdata_wr <= 8'h7a), 1);
`endif
      end else if (vmdata_wren) begin
        m_dur++;
        if ({vmdata_wraddr, vmdata_wr, veldata_wr} != {cur.col, cur.ch, cur.vel}) m_unst++;
      end else if (m_inw) begin
        m_inw = 0;
        chk("wren_duration", m_dur, cur.dur);
        chk("hold_stable", m_unst, 0);
      end
    end
  end

  initial begin
    #900_000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int n, rounds, k;
    bit pb, wrote;
    reset = 1;
    pause = 0;
    mode = 2'd1;
    foreach (occ[i]) occ[i] = 0;
    m_lfsr = 16'hACE1;
    repeat (3) @(negedge clk);
    chk("rst_wren", vmdata_wren, 0);
    chk("rst_wr", vmdata_wr, 0);
    chk("rst_addr", vmdata_wraddr, 0);
    chk("rst_vel", veldata_wr, 0);
    chk("rst_spawn", spawn_count, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_busy", busy, 0);
    reset = 0;
    repeat (20) @(negedge clk);
    chk("paused_busy", busy, 0);
    chk("paused_wren", vmdata_wren, 0);
    // first spawn from the seed, slot free, committed 50 clk into WRITE
    plan_round(50, wrote);
    pause = 1;
    wait_for(0, 1, "busy_rise");
    n = 0;
    while (!vmdata_wren && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("roll_to_wren", n, 3);
    pause = 0;
    wait_for(1, 0, "commit");
    chk("spawn_after_commit", spawn_count, 1);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("cool_len", n, COOL);
    // every slot occupied: one full give-up round
    foreach (occ[i]) occ[i] = 1;
    plan_round(0, wrote);
    pause = 1;
    wait_for(0, 1, "giveup_start");
    pause = 0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("giveup_busy_len", n, 8 * 3 + COOL);
    chk("giveup_last_col", vmdata_wraddr, m_col(m_lfsr));
    chk("giveup_spawn", spawn_count, 1);
    chk("giveup_drop", drop_count, 0);
    // randomized rounds; first writes cover commit-on-timeout-cycle, timeout, instant commit
    foreach (occ[i]) occ[i] = $urandom_range(0, 99) < 80;
    k = 0;
    for (int r = 0; r < NROUNDS; r++) begin
      plan_round(k == 0 ? WTO - 1 : k == 1 ? WTO : k == 2 ? 0 : int'($urandom_range(0, 70)), wrote);
      if (wrote) k++;
    end
    rounds = 0;
    pb = busy;
    for (int cyc = 0; cyc < 60000 && rounds < NROUNDS; cyc++) begin
      @(negedge clk);
      if (pb && !busy) rounds++;
      pb = busy;
      pause = rounds < NROUNDS && $urandom_range(0, 3) != 0;
    end
    chk("rounds_done", rounds, NROUNDS);
    repeat (5) @(negedge clk);
    chk("rand_queue_empty", exp_q.size(), 0);
    chk("rand_spawn", spawn_count, exp_spawn);
    chk("rand_drop", drop_count, exp_drop);
    // asynchronous reset in the middle of a held write
    foreach (occ[i]) occ[i] = 0;
    plan_round(100000, wrote);
    pause = 1;
    wait_for(1, 1, "write_before_reset");
    pause = 0;
    repeat (10) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("async_rst_wren", vmdata_wren, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_spawn", spawn_count, 0);
    chk("async_rst_drop", drop_count, 0);
    chk("async_rst_addr", vmdata_wraddr, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    exp_q.delete();
    plan_q.delete();
    m_lfsr = 16'hACE1;
    exp_spawn = 0;
    exp_drop = 0;
    plan_round(5, wrote);
    pause = 1;
    wait_for(0, 1, "post_rst_start");
    pause = 0;
    wait_for(0, 0, "post_rst_end");
    chk("post_rst_spawn", spawn_count, exp_spawn);
    chk("post_rst_drop", drop_count, exp_drop);
    chk("post_rst_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
